// File: rtl/count_pwm_stage.sv
// PWM stage driven by a free-running mod-16 counter: duty in sixteenths, updates
// taken through valid/ready and applied only at period boundaries, plus wrap/period/sequence tracking.
module count_pwm_stage #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          count,
  input  logic [4:0]          duty_data,
  input  logic                duty_valid,
  output logic                duty_ready,
  output logic                pwm_out,
  output logic                wrap_pulse,
  output logic [PERIOD_W-1:0] period_cnt,
  output logic                seq_err
);

  logic [3:0]          r_prev_count;
  logic                r_prev_valid;
  logic [4:0]          r_active_duty;
  logic [4:0]          r_pend_duty;
  logic                r_pend_flag;
  logic                r_pwm;
  logic                r_wrap;
  logic [PERIOD_W-1:0] r_period_cnt;
  logic                r_seq_err;

  logic [3:0] w_next_count;
  logic       w_wrap;
  logic       w_seq_break;
  logic       w_accept;
  logic       w_apply;
  logic [4:0] w_eff_duty;

  function automatic logic [4:0] sat_duty(input logic [4:0] d);
    return (d > 5'd16) ? 5'd16 : d;
  endfunction

  assign w_next_count = r_prev_count + 4'd1;
  assign w_wrap       = r_prev_valid && (r_prev_count == 4'd15) && (count == 4'd0);
  assign w_seq_break  = r_prev_valid && (count != w_next_count);
  assign w_accept     = duty_valid && !r_pend_flag;
  assign w_apply      = w_wrap && r_pend_flag;
  // A pending duty is used for the count==0 slot itself, so the new period is whole.
  assign w_eff_duty   = w_apply ? r_pend_duty : r_active_duty;

  // Stage p0 -> registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_count  <= 4'd0;
      r_prev_valid  <= 1'b0;
      r_active_duty <= 5'd0;
      r_pend_duty   <= 5'd0;
      r_pend_flag   <= 1'b0;
      r_pwm         <= 1'b0;
      r_wrap        <= 1'b0;
      r_period_cnt  <= '0;
      r_seq_err     <= 1'b0;
    end else begin
      r_prev_count <= count;
      r_prev_valid <= 1'b1;
      r_pwm        <= ({1'b0, count} < w_eff_duty);
      r_wrap       <= w_wrap;
      if (w_wrap)
        r_period_cnt <= r_period_cnt + PERIOD_W'(1);
      if (w_seq_break)
        r_seq_err <= 1'b1;
      // Accept and apply are exclusive: accept needs pend_flag low, apply needs it high.
      if (w_apply) begin
        r_active_duty <= r_pend_duty;
        r_pend_flag   <= 1'b0;
      end else if (w_accept) begin
        r_pend_duty <= sat_duty(duty_data);
        r_pend_flag <= 1'b1;
      end
    end
  end

  assign duty_ready = !r_pend_flag;
  assign pwm_out    = r_pwm;
  assign wrap_pulse = r_wrap;
  assign period_cnt = r_period_cnt;
  assign seq_err    = r_seq_err;

endmodule

// File: tb/tb_count_pwm_stage.sv
// Scoreboard bench for count_pwm_stage: the driver pushes the expected outputs for
// each clock edge, and a monitor pops and compares them one edge at a time.
module tb_count_pwm_stage;
  localparam int PERIOD_W = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic [3:0]          count;
  logic [4:0]          duty_data;
  logic                duty_valid;
  logic                duty_ready;
  logic                pwm_out;
  logic                wrap_pulse;
  logic [PERIOD_W-1:0] period_cnt;
  logic                seq_err;

  always #5 clk = ~clk;

  count_pwm_stage #(.PERIOD_W(PERIOD_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .count      (count),
    .duty_data  (duty_data),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .pwm_out    (pwm_out),
    .wrap_pulse (wrap_pulse),
    .period_cnt (period_cnt),
    .seq_err    (seq_err)
  );

  typedef struct packed {
    logic                pwm;
    logic                wrap;
    logic [PERIOD_W-1:0] pcnt;
    logic                serr;
    logic                rdy;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_cyc = 0;

  // Scenario expectations: duty in force, duty waiting for the next wrap, etc.
  logic [3:0]          lastc   = 4'd15;
  bit                  started = 0;
  logic [4:0]          e_duty  = 5'd0;
  logic [4:0]          sw_duty = 5'd0;
  bit                  armed   = 0;
  logic                e_rdy   = 1'b1;
  logic [PERIOD_W-1:0] e_pcnt  = '0;
  logic                e_serr  = 1'b0;

  task automatic cmp(input string nm, input exp_t e);
    n_vec++;
    if (pwm_out !== e.pwm || wrap_pulse !== e.wrap || period_cnt !== e.pcnt ||
        seq_err !== e.serr || duty_ready !== e.rdy) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got pwm=%b wrap=%b pcnt=%0d serr=%b rdy=%b, required pwm=%b wrap=%b pcnt=%0d serr=%b rdy=%b",
               nm, n_cyc, pwm_out, wrap_pulse, period_cnt, seq_err, duty_ready,
               e.pwm, e.wrap, e.pcnt, e.serr, e.rdy);
    end
  endtask

  // One clock of stimulus; d_clamped is the hand-computed duty that an accept of d should install.
  task automatic tick(input logic [3:0] c, input logic v, input logic [4:0] d, input logic [4:0] d_clamped);
    bit   acc;
    bit   w;
    exp_t e;
    @(negedge clk);
    reset      = 1'b0;
    count      = c;
    duty_valid = v;
    duty_data  = d;
    acc = v && e_rdy;
    w   = started && (lastc == 4'd15) && (c == 4'd0);
    if (w) begin
      e_pcnt = e_pcnt + 1'b1;
      if (armed) begin
        e_duty = sw_duty;
        armed  = 0;
        e_rdy  = 1'b1;
      end
    end
    if (acc) begin
      sw_duty = d_clamped;
      armed   = 1;
      e_rdy   = 1'b0;
    end
    if (started && (c != 4'(lastc + 4'd1)))
      e_serr = 1'b1;
    e.pwm  = ({1'b0, c} < e_duty);
    e.wrap = w;
    e.pcnt = e_pcnt;
    e.serr = e_serr;
    e.rdy  = e_rdy;
    sb.push_back(e);
    started = 1;
    lastc   = c;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++)
      tick(4'(lastc + 4'd1), 1'b0, 5'd0, 5'd0);
  endtask

  task automatic offer(input logic [4:0] d, input logic [4:0] d_clamped);
    tick(4'(lastc + 4'd1), 1'b1, d, d_clamped);
  endtask

  task automatic do_reset(input int n);
    exp_t r;
    r.pwm = 1'b0; r.wrap = 1'b0; r.pcnt = '0; r.serr = 1'b0; r.rdy = 1'b1;
    @(negedge clk);
    reset      = 1'b1;
    count      = 4'd0;
    duty_valid = 1'b0;
    duty_data  = 5'd0;
    #1;
    cmp("async_reset", r);
    sb.push_back(r);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      sb.push_back(r);
    end
    lastc   = 4'd15;
    started = 0;
    e_duty  = 5'd0;
    sw_duty = 5'd0;
    armed   = 0;
    e_rdy   = 1'b1;
    e_pcnt  = '0;
    e_serr  = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      n_cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("cycle", e);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, required completion within 1 ms");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "timeout");
  end

  initial begin : driver
    reset      = 1'b1;
    count      = 4'd0;
    duty_valid = 1'b0;
    duty_data  = 5'd0;

    // 100 ns reset hold, then counter running with duty 0
    do_reset(10);
    step(40);

    // Duty 5 mid-period; data changes while not ready must be ignored
    offer(5'd5, 5'd5);
    tick(4'(lastc + 4'd1), 1'b1, 5'd31, 5'd16);
    tick(4'(lastc + 4'd1), 1'b1, 5'd2, 5'd2);
    step(48);

    // Duty 0, 16, then 20 which clamps to 16
    offer(5'd0, 5'd0);
    step(40);
    offer(5'd16, 5'd16);
    step(40);
    offer(5'd20, 5'd16);
    step(40);

    // Duty 9 offered in the very cycle the wrap is detected
    while (lastc != 4'd15) step(1);
    tick(4'd0, 1'b1, 5'd9, 5'd9);
    step(40);

    // 256 periods: period_cnt rolls 255 -> 0
    step(16 * 256);

    // Count skips 6 -> 8
    while (lastc != 4'd6) step(1);
    tick(4'd8, 1'b0, 5'd0, 5'd0);
    step(40);

    // Reset mid-period with a pending duty: it must never be applied
    while (lastc != 4'd4) step(1);
    offer(5'd12, 5'd12);
    step(3);
    do_reset(3);
    step(40);

    @(negedge clk);
    duty_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
